// File: rtl/forward_ctrl_pkg.sv
// Shared forwarding definitions: mux select codes, the default
// register-address width and the issue-history entry type.
package forward_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WBBUF = 2'd3;

  localparam int REG_AW_DEF = 5;

  // rd field is sized for the widest supported address; narrower
  // configurations zero-extend into it.
  localparam int REG_AW_MAX = 8;

  // valid is only set for accepted instructions that write a register.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  load;
  } hist_t;

endpackage

// File: rtl/forward_ctrl_match.sv
// One source operand against the T1..T3 history; the youngest
// writer wins and register 0 never matches.
module fwd_match
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  hist_t             t1,
  input  hist_t             t2,
  input  hist_t             t3,
  output logic [1:0]        sel
);

  logic [REG_AW_MAX-1:0] src_x;
  logic                  hit1;
  logic                  hit2;
  logic                  hit3;

  assign src_x = REG_AW_MAX'(src);

  assign hit1 = t1.valid && (t1.rd != '0) && (t1.rd == src_x);
  assign hit2 = t2.valid && (t2.rd != '0) && (t2.rd == src_x);
  assign hit3 = t3.valid && (t3.rd != '0) && (t3.rd == src_x);

  // Priority encode, youngest producer first.
  always_comb begin
    sel = FWD_RF;
    if (hit1)      sel = FWD_EXMEM;
    else if (hit2) sel = FWD_MEMWB;
    else if (hit3) sel = FWD_WBBUF;
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding select and load-use stall control for the EX stage.
// Optional stall counter enabled by FORWARD_CTRL_STATS_EN.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wen,
  input  logic              issue_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef FORWARD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  hist_t t1_q, t2_q, t3_q;
  hist_t t1_d, t2_d, t3_d;

  logic [1:0] sel_a, sel_b;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;

  logic [REG_AW_MAX-1:0] rs_x, rt_x;
  logic                  t1_ld_wr;
  logic                  accept;

  assign rs_x = REG_AW_MAX'(issue_rs);
  assign rt_x = REG_AW_MAX'(issue_rt);

  assign t1_ld_wr = t1_q.valid && t1_q.load
                 && (t1_q.rd != '0);

  assign stall = issue_valid && !flush && t1_ld_wr
              && ((t1_q.rd == rs_x) || (t1_q.rd == rt_x));

  assign accept = issue_valid && !stall && !flush;

  fwd_match #(.REG_AW(REG_AW)) u_match_a (
    .src (issue_rs),
    .t1  (t1_q),
    .t2  (t2_q),
    .t3  (t3_q),
    .sel (sel_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_b (
    .src (issue_rt),
    .t1  (t1_q),
    .t2  (t2_q),
    .t3  (t3_q),
    .sel (sel_b)
  );

  // Shift history every cycle; bubbles on stall/flush, flush kills old T1.
  always_comb begin
    t1_d = '0;
    if (accept) begin
      t1_d.valid = issue_wen;
      t1_d.rd    = REG_AW_MAX'(issue_rd);
      t1_d.load  = issue_load;
    end
    t2_d = t1_q;
    if (flush) t2_d.valid = 1'b0;
    t3_d    = t2_q;
    fwd_a_d = accept ? sel_a : FWD_RF;
    fwd_b_d = accept ? sel_b : FWD_RF;
  end

  // History and select registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef FORWARD_CTRL_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized and directed bench for forward_ctrl against a
// queue-based model of issued instructions.
module tb_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rs = '0;
  logic [AW-1:0] issue_rt = '0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_wen = 1'b0;
  logic          issue_load = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
`ifdef FORWARD_CTRL_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .issue_rd    (issue_rd),
    .issue_wen   (issue_wen),
    .issue_load  (issue_load),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
`ifdef FORWARD_CTRL_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One record per clock edge: what entered the pipeline that cycle.
  typedef struct {
    bit w;
    int rd;
    bit ld;
  } ent_t;

  ent_t hq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Did the instruction issued k cycles ago write register r?
  function automatic bit wrote(int k, int r);
    int n;
    n = hq.size();
    if (n < k) return 1'b0;
    return hq[n-k].w && (hq[n-k].rd != 0) && (hq[n-k].rd == r);
  endfunction

  function automatic bit loaded(int k);
    int n;
    n = hq.size();
    if (n < k) return 1'b0;
    return hq[n-k].ld;
  endfunction

  function automatic int src_sel(int r);
    for (int k = 1; k <= 3; k++)
      if (wrote(k, r)) return k;
    return 0;
  endfunction

  task automatic tick(bit v, int rs, int rt, int rd,
                      bit wen, bit ld, bit fl);
    bit st;
    bit acc;
    int ea;
    int eb;
    @(negedge clk);
    issue_valid = v;
    issue_rs    = AW'(rs);
    issue_rt    = AW'(rt);
    issue_rd    = AW'(rd);
    issue_wen   = wen;
    issue_load  = ld;
    flush       = fl;
    #1;
    st = v && !fl && loaded(1) && (wrote(1, rs) || wrote(1, rt));
    if (rst_n) chk("stall", {31'd0, stall}, {31'd0, st});
    acc = v && !st && !fl;
    ea  = acc ? src_sel(rs) : 0;
    eb  = acc ? src_sel(rt) : 0;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      hq.delete();
      ea      = 0;
      eb      = 0;
      exp_cnt = 0;
    end else begin
      if (st && exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (fl && hq.size() > 0) hq[hq.size()-1].w = 1'b0;
      hq.push_back('{w: acc && wen, rd: rd, ld: acc && ld});
    end
    chk("fwd_a", {30'd0, fwd_a}, ea);
    chk("fwd_b", {30'd0, fwd_b}, eb);
`ifdef FORWARD_CTRL_STATS_EN
    chk("stall_cnt", {28'd0, stall_cnt}, exp_cnt);
`endif
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with a busy-looking input pattern.
    rst_n = 1'b0;
    tick(1, 3, 4, 3, 1, 1, 0);
    tick(1, 3, 4, 3, 1, 1, 0);
    rst_n = 1'b1;
    idle();
    idle();
    idle();

    // add r3 then sub using r3.
    tick(1, 1, 2, 3, 1, 0, 0);
    tick(1, 3, 6, 8, 1, 0, 0);
    chk("s030_a", {30'd0, fwd_a}, 1);
    chk("s030_b", {30'd0, fwd_b}, 0);
    idle(); idle(); idle();

    // writer r5, two gaps, user rt=r5; then one gap.
    tick(1, 1, 2, 5, 1, 0, 0);
    tick(1, 1, 2, 9, 0, 0, 0);
    tick(1, 1, 2, 9, 0, 0, 0);
    tick(1, 1, 5, 9, 0, 0, 0);
    chk("s031_gap2", {30'd0, fwd_b}, 3);
    tick(1, 1, 2, 5, 1, 0, 0);
    tick(1, 1, 2, 9, 0, 0, 0);
    tick(1, 1, 5, 9, 0, 0, 0);
    chk("s031_gap1", {30'd0, fwd_b}, 2);
    idle(); idle(); idle();

    // lw r7 then immediate user: one stall, then select 2.
    tick(1, 1, 2, 7, 1, 1, 0);
    tick(1, 7, 2, 10, 1, 0, 0);
    tick(1, 7, 2, 10, 1, 0, 0);
    chk("s032_a", {30'd0, fwd_a}, 2);
    idle(); idle(); idle();

    // writer r0 never forwards.
    tick(1, 1, 2, 0, 1, 0, 0);
    tick(1, 0, 0, 4, 1, 0, 0);
    chk("s033_a", {30'd0, fwd_a}, 0);
    idle(); idle(); idle();

    // flush during load-use; later user of r7 reads register file.
    tick(1, 1, 2, 7, 1, 1, 0);
    tick(1, 7, 2, 10, 1, 0, 1);
    tick(1, 7, 7, 11, 1, 0, 0);
    chk("s034_a", {30'd0, fwd_a}, 0);
    idle(); idle(); idle();

    // Reset mid-stall abandons everything.
    tick(1, 1, 2, 6, 1, 1, 0);
    rst_n = 1'b0;
    tick(1, 6, 2, 10, 1, 0, 0);
    rst_n = 1'b1;
    tick(1, 6, 6, 10, 1, 0, 0);
    chk("reset_stall_a", {30'd0, fwd_a}, 0);

    // Randomized traffic over a small register set for frequent hits.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 9) < 8,
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0);
    end

    // Many load-use stalls to saturate the counter.
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      tick(1, 1, 2, 7, 1, 1, 0);
      tick(1, 7, 2, 10, 1, 0, 0);
    end
`ifdef FORWARD_CTRL_STATS_EN
    chk("cnt_sat", {28'd0, stall_cnt}, 15);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("cnt_rst", {28'd0, stall_cnt}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
